fmul_pipe: RTL and testbench
============================

FMUL_PIPE -- requirements
Module: fmul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand pair valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port num1, num2  input  W each  IEEE-style operands {sign, exp, frac}.
REQ-008 SHALL have port rm  input  3  rounding mode, sampled with operands.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_mul  output  W  rounded product.
REQ-012 SHALL have port flags  output  5  {NV, DZ, OF, UF, NX}.

Function
REQ-013 SHALL be a 3-stage pipeline: S1 unpack/special-case detect, S2 significand multiply, S3 normalise/round/pack; latency exactly 3 cycles from accept to out_valid with no stall.
REQ-014 SHALL accept a transfer when in_valid && in_ready and retire one when out_valid && out_ready.
REQ-015 SHALL drive in_ready = !out_valid || out_ready; on stall all stages hold and no result is lost, duplicated or reordered.
REQ-016 SHALL sustain one result per cycle when out_ready is held high.
REQ-017 SHALL hold out_mul and flags stable while out_valid && !out_ready.
REQ-018 SHALL compute bias = 2^(EXP_W-1)-1, sign = num1[W-1]^num2[W-1], product width 2*(MAN_W+1), and at most a 1-bit normalising right shift.
REQ-019 SHALL round using guard, round and sticky bits: rm 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; rm 101-111 are treated as RNE.
REQ-020 SHALL flush subnormal inputs to signed zero (DAZ), with no flag raised.
REQ-021 SHALL flush tiny results (exponent after rounding < 1) to signed zero, setting UF and NX.
REQ-022 SHALL handle overflow as follows: RNE/RMM give signed infinity; RTZ gives max finite; RDN gives +max or -inf; RUP gives +inf or -max; OF and NX are set in all cases.
REQ-023 SHALL return canonical qNaN (exp all-ones, frac MSB 1, rest 0, sign 0) for any NaN operand; NV is set only for a signalling-NaN operand or for inf*0.
REQ-024 SHALL return signed infinity for inf*finite-nonzero and signed zero for zero*finite, with no flags.
REQ-025 SHALL hold DZ at 0 always, and set NX whenever any discarded bit is nonzero.

Reset
REQ-026 SHALL, while rst is high at a clock edge, clear all stage valid bits, out_valid, out_mul and flags to 0.
REQ-027 SHALL discard in-flight operations on reset mid-operation; no result from before reset appears afterwards.
REQ-028 SHALL drive in_ready high in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL, with FMUL_PIPE_FLAGS_EN defined, compute and register flags per REQ-021..025 alongside each result.
REQ-030 SHALL, without FMUL_PIPE_FLAGS_EN, tie flags to 5'b0 and synthesise no flag logic; out_mul is unchanged.

Verification
REQ-031 SHALL be verified with 0x3FC00000*0x40000000, rm=000 -> 0x40400000 exactly 3 cycles after accept, flags 5'b00000.
REQ-032 SHALL be verified with 0x7F800000*0x00000000 -> 0x7FC00000, flags 5'b10000; 0x7FC00000*0x3F800000 -> 0x7FC00000, flags 0.
REQ-033 SHALL be verified with 0x7F7FFFFF*0x40000000: rm=001 -> 0x7F7FFFFF; rm=000 -> 0x7F800000; flags 5'b00101 in both cases.
REQ-034 SHALL be verified with 0x3F800001*0x3F800001: rm=000 -> 0x3F800002, rm=011 -> 0x3F800003, rm=001 -> 0x3F800002, each with NX set.
REQ-035 SHALL be verified with 6 back-to-back inputs and out_ready low for cycles 2-6: in_ready drops, and all 6 results emerge in order with none lost or duplicated.
REQ-036 SHALL be verified with rst pulsed 1 cycle while 2 operations are in flight: out_valid stays 0 until a new operand is accepted, then exactly that result appears 3 cycles later.

Source files
------------

// File: rtl/fmul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fmul_pipe
// Purpose  : Three-stage pipelined IEEE-style floating-point multiplier with
//            valid/ready handshaking on both sides.
//              S1 unpack, subnormal flush (DAZ), special-case detection
//              S2 significand multiply
//              S3 normalise (at most one right shift), round, pack
//            All stages advance together, and only when the output register
//            can take a new value. A stall therefore freezes the whole
//            pipe in place.
// Ports    : clk        sole clock, rising edge
//            rst        synchronous active-high reset
//            in_valid   operand pair valid
//            in_ready   operands accepted this cycle (!out_valid || out_ready)
//            num1/num2  operands {sign, exp[EXP_W], frac[MAN_W]}
//            rm         rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM,
//                       5..7 behave as RNE
//            out_valid  result valid
//            out_ready  consumer takes the result this cycle
//            out_mul    rounded product
//            flags      {NV, DZ, OF, UF, NX}
// Config   : define FMUL_PIPE_FLAGS_EN to compute and register the exception
//            flags. Without it, flags is tied to zero and no flag logic exists.
// Revision : 1.0  initial release
// ============================================================================
module fmul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   num1,
  input  logic [EXP_W+MAN_W:0]   num2,
  input  logic [2:0]             rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_mul,
  output logic [4:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;          // significand width incl. hidden bit
  localparam int PW = 2 * SW;             // full product width
  localparam int XW = EXP_W + 2;          // signed working exponent width
  localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] ONE     = XW'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  // Global advance: every stage moves when the output slot is free or draining.
  logic adv;
  assign in_ready = !out_valid || out_ready;
  assign adv      = in_ready;

  // --------------------------------------------------------------------------
  // S1: unpack and classify
  // --------------------------------------------------------------------------
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  assign {sign_a, exp_a, frac_a} = num1;
  assign {sign_b, exp_b, frac_b} = num2;

  logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  // Exponent zero covers both true zero and subnormals (flushed to zero).
  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);
  assign inf_a  = (&exp_a) && (frac_a == '0);
  assign inf_b  = (&exp_b) && (frac_b == '0);
  assign nan_a  = (&exp_a) && (frac_a != '0);
  assign nan_b  = (&exp_b) && (frac_b != '0);

  logic             prod_sign, inf_x_zero, any_nan, is_special;
  logic [W-1:0]     special_res;
  logic signed [XW-1:0] exp_sum;
  assign prod_sign  = sign_a ^ sign_b;
  assign inf_x_zero = (inf_a && zero_b) || (inf_b && zero_a);
  assign any_nan    = nan_a || nan_b;
  assign is_special = any_nan || inf_a || inf_b || zero_a || zero_b;
  assign exp_sum    = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;

  always_comb begin
    if (any_nan || inf_x_zero) special_res = QNAN;
    else if (inf_a || inf_b)   special_res = {prod_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else                       special_res = {prod_sign, {(W-1){1'b0}}};
  end

  logic                 s1_valid, s1_sign, s1_special;
  logic [W-1:0]         s1_special_res;
  logic [SW-1:0]        s1_sig_a, s1_sig_b;
  logic signed [XW-1:0] s1_exp;
  logic [2:0]           s1_rm;

  // --------------------------------------------------------------------------
  // S2: significand multiply
  // --------------------------------------------------------------------------
  logic                 s2_valid, s2_sign, s2_special;
  logic [W-1:0]         s2_special_res;
  logic [PW-1:0]        s2_prod;
  logic signed [XW-1:0] s2_exp;
  logic [2:0]           s2_rm;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign        <= prod_sign;
      s1_special     <= is_special;
      s1_special_res <= special_res;
      s1_sig_a       <= {1'b1, frac_a};
      s1_sig_b       <= {1'b1, frac_b};
      s1_exp         <= exp_sum;
      s1_rm          <= rm;
      s2_sign        <= s1_sign;
      s2_special     <= s1_special;
      s2_special_res <= s1_special_res;
      s2_prod        <= {{SW{1'b0}}, s1_sig_a} * {{SW{1'b0}}, s1_sig_b};
      s2_exp         <= s1_exp;
      s2_rm          <= s1_rm;
    end
  end

  // --------------------------------------------------------------------------
  // S3: normalise, round, pack
  // --------------------------------------------------------------------------
  // norm holds the bits below the leading one; product lies in [1,4).
  logic [PW-2:0]        norm;
  logic [MAN_W-1:0]     frac_t, frac_r;
  logic                 guard_bit, round_bit, sticky_bit, discard, inc, carry;
  logic signed [XW-1:0] exp_n, exp_r;
  logic                 tiny, ovf;

  always_comb begin
    norm       = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
    exp_n      = s2_exp + $signed({{(XW-1){1'b0}}, s2_prod[PW-1]});
    frac_t     = norm[PW-2 -: MAN_W];
    guard_bit  = norm[MAN_W];
    round_bit  = norm[MAN_W-1];
    sticky_bit = |norm[MAN_W-2:0];
    discard    = guard_bit || round_bit || sticky_bit;
    case (s2_rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = discard && s2_sign;
      RM_RUP:  inc = discard && !s2_sign;
      RM_RMM:  inc = guard_bit;
      default: inc = guard_bit && (round_bit || sticky_bit || frac_t[0]);
    endcase
    // An all-ones fraction that rounds up wraps to zero and bumps the exponent.
    frac_r = frac_t + {{(MAN_W-1){1'b0}}, inc};
    carry  = inc && (&frac_t);
    exp_r  = exp_n + $signed({{(XW-1){1'b0}}, carry});
    tiny   = (exp_r < ONE);
    ovf    = (exp_r >= EXP_MAX);
  end

  logic [W-1:0] inf_res, max_res, result;
  assign inf_res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign max_res = {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

  always_comb begin
    result = {s2_sign, exp_r[EXP_W-1:0], frac_r};
    if (s2_special) begin
      result = s2_special_res;
    end else if (ovf) begin
      case (s2_rm)
        RM_RTZ:  result = max_res;
        RM_RDN:  result = s2_sign ? inf_res : max_res;
        RM_RUP:  result = s2_sign ? max_res : inf_res;
        default: result = inf_res;
      endcase
    end else if (tiny) begin
      result = {s2_sign, {(W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  out_mul <= '0;
    else if (adv && s2_valid) out_mul <= result;
  end

`ifdef FMUL_PIPE_FLAGS_EN
  // Signalling NaN has the fraction MSB clear.
  logic snan_any, s1_spec_nv, s2_spec_nv;
  assign snan_any = (nan_a && !frac_a[MAN_W-1]) || (nan_b && !frac_b[MAN_W-1]);

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_spec_nv <= snan_any || inf_x_zero;
      s2_spec_nv <= s1_spec_nv;
    end
  end

  logic [4:0] flags_d, flags_q;
  always_comb begin
    flags_d = 5'b00000;
    if (s2_special) flags_d = {s2_spec_nv, 4'b0000};
    else if (ovf)   flags_d = 5'b00101;
    else if (tiny)  flags_d = 5'b00011;
    else            flags_d = {4'b0000, discard};
  end

  always_ff @(posedge clk) begin
    if (rst)                  flags_q <= 5'b00000;
    else if (adv && s2_valid) flags_q <= flags_d;
  end

  assign flags = flags_q;
`else
  assign flags = 5'b00000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fmul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmul_pipe
// Purpose  : Directed, table-driven bench for fmul_pipe (binary32 config).
//            Expected flags are masked to zero when FMUL_PIPE_FLAGS_EN is
//            not defined, since the block then ties flags low.
// Revision : 1.0  initial release
// ============================================================================
module tb_fmul_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 32;
`ifdef FMUL_PIPE_FLAGS_EN
  localparam logic [4:0] FMASK = 5'h1F;
`else
  localparam logic [4:0] FMASK = 5'h00;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] num1, num2, out_mul;
  logic [2:0]   rm;
  logic [4:0]   flags;

  fmul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num1      (num1),
    .num2      (num2),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mul   (out_mul),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;

  vec_t        tab[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [36:0] got_q[$];
  int          sent, vcount;
  logic        saw_low, stalled_prev, acc;
  logic [31:0] prev_mul;
  logic [4:0]  prev_fl;

  task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                     input logic [31:0] res, input logic [4:0] fl);
    vec_t v;
    v.a = a; v.b = b; v.rm = m; v.res = res; v.fl = fl;
    tab.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, got, want);
    end
  endtask

  // Apply one operand pair, wait for its result, check latency/value/flags,
  // then let it retire.
  task automatic run_one(input int idx, input vec_t v);
    int lat;
    num1 = v.a; num2 = v.b; rm = v.rm; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", idx, 32'(lat), 32'd3);
    check("out_mul", idx, out_mul, v.res);
    check("flags",   idx, 32'(flags), 32'(v.fl & FMASK));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    num1 = '0; num2 = '0; rm = 3'd0;

    //   a             b             rm    result        {NV,DZ,OF,UF,NX}
    add(32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000); // 1.5*2
    add(32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b10000); // inf*0
    add(32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b00000); // qNaN*1
    add(32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 5'b00101); // ovf RTZ
    add(32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 5'b00101); // ovf RNE
    add(32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 5'b00001);
    add(32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 5'b00001);
    add(32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 5'b00001);
    add(32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b10000); // sNaN
    add(32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 5'b00000); // -inf*2
    add(32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 5'b00000); // -0*1
    add(32'h00000001, 32'h3F800000, 3'd0, 32'h00000000, 5'b00000); // DAZ
    add(32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 5'b00011); // tiny
    add(32'h80800000, 32'h3F000000, 3'd0, 32'h80000000, 5'b00011); // -tiny
    add(32'h00800000, 32'h3F800000, 3'd0, 32'h00800000, 5'b00000); // min normal
    add(32'h7F7FFFFF, 32'h40000000, 3'd2, 32'h7F7FFFFF, 5'b00101); // ovf RDN +
    add(32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 5'b00101); // ovf RDN -
    add(32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 5'b00101); // ovf RUP -
    add(32'hFF7FFFFF, 32'h40000000, 3'd1, 32'hFF7FFFFF, 5'b00101); // ovf RTZ -
    add(32'h7F7FFFFF, 32'h40000000, 3'd4, 32'h7F800000, 5'b00101); // ovf RMM
    add(32'h7F7FFFFF, 32'h40000000, 3'd7, 32'h7F800000, 5'b00101); // rm 7 = RNE
    add(32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 5'b00001); // tie, even
    add(32'h3F800003, 32'h3FC00000, 3'd4, 32'h3FC00005, 5'b00001); // tie, RMM
    add(32'h3FFFFFFE, 32'h3F800001, 3'd0, 32'h40000000, 5'b00001); // round carry
    add(32'h3FFFFFFE, 32'h3F800001, 3'd1, 32'h3FFFFFFF, 5'b00001);
    add(32'h40400000, 32'hC0A00000, 3'd0, 32'hC1700000, 5'b00000); // 3*-5
    add(32'h3FFFFFFF, 32'h3FFFFFFF, 3'd0, 32'h407FFFFE, 5'b00001); // norm shift
    add(32'h3FFFFFFF, 32'h3FFFFFFF, 3'd3, 32'h407FFFFF, 5'b00001);
    add(32'h7FC00000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b00000); // qNaN*0
    add(32'hFF800001, 32'h7F800000, 3'd0, 32'h7FC00000, 5'b10000); // sNaN*inf
    add(32'h00000000, 32'hFF800000, 3'd0, 32'h7FC00000, 5'b10000); // 0*-inf
    add(32'h7F800000, 32'h7F800000, 3'd0, 32'h7F800000, 5'b00000); // inf*inf
    add(32'hBF800001, 32'h3F800001, 3'd2, 32'hBF800003, 5'b00001); // RDN -
    add(32'hBF800001, 32'h3F800001, 3'd3, 32'hBF800002, 5'b00001); // RUP -

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 0, 32'(out_valid), 32'd0);
    check("rst_out_mul",   0, out_mul,        32'd0);
    check("rst_flags",     0, 32'(flags),     32'd0);
    check("rst_in_ready",  0, 32'(in_ready),  32'd1);

    for (int i = 0; i < tab.size(); i++) run_one(i, tab[i]);

    // Six back-to-back operands, consumer stalls for cycles 2..6.
    sent = 0; saw_low = 1'b0; stalled_prev = 1'b0;
    prev_mul = '0; prev_fl = '0;
    for (int c = 0; c < 40; c++) begin
      in_valid = (sent < 6);
      if (sent < 6) begin
        num1 = tab[sent].a; num2 = tab[sent].b; rm = tab[sent].rm;
      end
      out_ready = !(c >= 2 && c <= 6);
      @(negedge clk);
      if (!in_ready) saw_low = 1'b1;
      if (stalled_prev) begin
        check("hold_mul",   c, out_mul,     prev_mul);
        check("hold_flags", c, 32'(flags),  32'(prev_fl));
      end
      stalled_prev = out_valid && !out_ready;
      prev_mul = out_mul;
      prev_fl  = flags;
      if (out_valid && out_ready) got_q.push_back({out_mul, flags});
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stall_in_ready_low", 0, 32'(saw_low),      32'd1);
    check("stall_count",        0, 32'(got_q.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < got_q.size()) begin
        check("stall_mul",   k, got_q[k][36:5],     tab[k].res);
        check("stall_flags", k, 32'(got_q[k][4:0]), 32'(tab[k].fl & FMASK));
      end
    end

    // Two operations in flight, then a one-cycle reset.
    num1 = tab[0].a; num2 = tab[0].b; rm = tab[0].rm; in_valid = 1'b1;
    @(posedge clk); #1;
    num1 = tab[3].a; num2 = tab[3].b; rm = tab[3].rm;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready",  0, 32'(in_ready),  32'd1);
    check("midrst_out_valid", 0, 32'(out_valid), 32'd0);
    check("midrst_out_mul",   0, out_mul,        32'd0);
    vcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("midrst_quiet", 0, 32'(vcount), 32'd0);
    @(posedge clk); #1;
    run_one(100, tab[25]);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
